// File: rtl/mp1_control_pkg.sv
// Shared RV32I control types: opcodes, ALU/compare ops, datapath mux selects and FSM states.
// RESET_STATE and MEM_MASK_W are the block's fixed configuration constants.
package mp1_control_pkg;

   localparam int MEM_MASK_W = 4;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   // Encoded so the arithmetic funct3 maps straight onto the ALU op for the common cases
   typedef enum logic [2:0] {
      alu_add = 3'b000,
      alu_sll = 3'b001,
      alu_sra = 3'b010,
      alu_sub = 3'b011,
      alu_xor = 3'b100,
      alu_srl = 3'b101,
      alu_or  = 3'b110,
      alu_and = 3'b111
   } alu_ops;

   typedef enum logic [2:0] {
      beq  = 3'b000,
      bne  = 3'b001,
      blt  = 3'b100,
      bge  = 3'b101,
      bltu = 3'b110,
      bgeu = 3'b111
   } branch_funct3_t;

   typedef enum logic [2:0] {
      f3_add  = 3'b000,
      f3_sll  = 3'b001,
      f3_slt  = 3'b010,
      f3_sltu = 3'b011,
      f3_xor  = 3'b100,
      f3_sr   = 3'b101,
      f3_or   = 3'b110,
      f3_and  = 3'b111
   } arith_funct3_t;

   typedef enum logic [2:0] {
      lb  = 3'b000,
      lh  = 3'b001,
      lw  = 3'b010,
      lbu = 3'b100,
      lhu = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      sb = 3'b000,
      sh = 3'b001,
      sw = 3'b010
   } store_funct3_t;

   typedef enum logic [1:0] {pcmux_pc_plus4, pcmux_alu_out, pcmux_alu_mod2} pcmux_sel_t;
   typedef enum logic {alumux1_rs1_out, alumux1_pc_out} alumux1_sel_t;
   typedef enum logic [2:0] {
      alumux2_i_imm, alumux2_u_imm, alumux2_b_imm, alumux2_s_imm, alumux2_j_imm, alumux2_rs2_out
   } alumux2_sel_t;
   typedef enum logic [3:0] {
      regfilemux_alu_out, regfilemux_br_en, regfilemux_u_imm, regfilemux_lw, regfilemux_pc_plus4,
      regfilemux_lb, regfilemux_lbu, regfilemux_lh, regfilemux_lhu
   } regfilemux_sel_t;
   typedef enum logic {marmux_pc_out, marmux_alu_out} marmux_sel_t;
   typedef enum logic {cmpmux_rs2_out, cmpmux_i_imm} cmpmux_sel_t;

   typedef enum logic [4:0] {
      s_fetch1, s_fetch2, s_fetch3, s_decode,
      s_imm, s_reg, s_lui, s_auipc, s_br, s_jal, s_jalr,
      s_calc_addr, s_ld1, s_ld2, s_st1, s_st2, s_trap
   } control_state_t;

   localparam control_state_t RESET_STATE = s_fetch1;

   function automatic logic opcode_known(rv32i_opcode op);
      case (op)
         op_lui, op_auipc, op_jal, op_jalr, op_br,
         op_load, op_store, op_imm, op_reg: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction

   // alt selects sub/sra; callers only raise it where funct7[5] is meaningful
   function automatic alu_ops arith_aluop(logic [2:0] funct3, logic alt);
      case (arith_funct3_t'(funct3))
         f3_add:  return alt ? alu_sub : alu_add;
         f3_sll:  return alu_sll;
         f3_xor:  return alu_xor;
         f3_sr:   return alt ? alu_sra : alu_srl;
         f3_or:   return alu_or;
         f3_and:  return alu_and;
         default: return alu_add;
      endcase
   endfunction

endpackage

// File: rtl/mp1_control_if.sv
// Control-unit <-> datapath/memory bundle. master = control unit, slave = datapath and memory side.
interface mp1_control_if;
   import mp1_control_pkg::*;

   rv32i_opcode                opcode;
   logic [2:0]                 funct3;
   logic [6:0]                 funct7;
   logic                       br_en;
   logic                       mem_resp;
   logic [1:0]                 mem_addr_lsb;

   logic                       load_pc;
   logic                       load_ir;
   logic                       load_regfile;
   logic                       load_mar;
   logic                       load_mdr;
   logic                       load_data_out;
   pcmux_sel_t                 pcmux_sel;
   alumux1_sel_t               alumux1_sel;
   alumux2_sel_t               alumux2_sel;
   regfilemux_sel_t            regfilemux_sel;
   marmux_sel_t                marmux_sel;
   cmpmux_sel_t                cmpmux_sel;
   alu_ops                     aluop;
   branch_funct3_t             cmpop;
   logic                       mem_read;
   logic                       mem_write;
   logic [MEM_MASK_W-1:0]      mem_byte_enable;
   logic                       illegal_instr;

   modport master (
      input  opcode, funct3, funct7, br_en, mem_resp, mem_addr_lsb,
      output load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
             pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel, cmpmux_sel,
             aluop, cmpop, mem_read, mem_write, mem_byte_enable, illegal_instr
   );

   modport slave (
      output opcode, funct3, funct7, br_en, mem_resp, mem_addr_lsb,
      input  load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out,
             pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel, cmpmux_sel,
             aluop, cmpop, mem_read, mem_write, mem_byte_enable, illegal_instr
   );

endinterface

// File: rtl/mp1_control_mem_mask_gen.sv
// Store byte-enable generator: width from funct3, placed by the address LSBs.
// Bytes shifted past the top lane are dropped; misalignment is not trapped.
module mem_mask_gen
   import mp1_control_pkg::*;
(
   input  logic [2:0]            funct3,
   input  logic [1:0]            addr_lsb,
   output logic [MEM_MASK_W-1:0] mask
);

   logic [MEM_MASK_W-1:0] base;

   always_comb begin
      case (store_funct3_t'(funct3))
         sb:      base = MEM_MASK_W'(1);
         sh:      base = MEM_MASK_W'(3);
         default: base = '1;
      endcase
   end

   assign mask = base << addr_lsb;

endmodule

// File: rtl/mp1_control.sv
// Multicycle RV32I control FSM driving datapath loads/selects and the memory handshake.
// Optional: define MP1_ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky state.
module mp1_control
   import mp1_control_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   mp1_control_if.master bus
);

   control_state_t        state_reg;
   logic [MEM_MASK_W-1:0] store_mask;

   mem_mask_gen u_mask (
      .funct3   (bus.funct3),
      .addr_lsb (bus.mem_addr_lsb),
      .mask     (store_mask)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= RESET_STATE;
      end else begin
         case (state_reg)
            s_fetch1: state_reg <= s_fetch2;
            s_fetch2: if (bus.mem_resp) state_reg <= s_fetch3;
            s_fetch3: state_reg <= s_decode;
            s_decode: begin
               case (bus.opcode)
                  op_imm:   state_reg <= s_imm;
                  op_reg:   state_reg <= s_reg;
                  op_lui:   state_reg <= s_lui;
                  op_auipc: state_reg <= s_auipc;
                  op_br:    state_reg <= s_br;
                  op_jal:   state_reg <= s_jal;
                  op_jalr:  state_reg <= s_jalr;
                  op_load,
                  op_store: state_reg <= s_calc_addr;
`ifdef MP1_ILLEGAL_TRAP_EN
                  default:  state_reg <= s_trap;
`else
                  default:  state_reg <= s_fetch1;
`endif
               endcase
            end
            s_calc_addr: state_reg <= (bus.opcode == op_store) ? s_st1 : s_ld1;
            s_ld1: if (bus.mem_resp) state_reg <= s_ld2;
            s_st1: if (bus.mem_resp) state_reg <= s_st2;
`ifdef MP1_ILLEGAL_TRAP_EN
            s_trap: state_reg <= s_trap;
`endif
            default: state_reg <= s_fetch1;
         endcase
      end
   end

   // Outputs stay at their defaults while reset is held so pending requests drop immediately
   always_comb begin
      bus.load_pc         = 1'b0;
      bus.load_ir         = 1'b0;
      bus.load_regfile    = 1'b0;
      bus.load_mar        = 1'b0;
      bus.load_mdr        = 1'b0;
      bus.load_data_out   = 1'b0;
      bus.pcmux_sel       = pcmux_pc_plus4;
      bus.alumux1_sel     = alumux1_rs1_out;
      bus.alumux2_sel     = alumux2_i_imm;
      bus.regfilemux_sel  = regfilemux_alu_out;
      bus.marmux_sel      = marmux_pc_out;
      bus.cmpmux_sel      = cmpmux_rs2_out;
      bus.aluop           = alu_add;
      bus.cmpop           = beq;
      bus.mem_read        = 1'b0;
      bus.mem_write       = 1'b0;
      bus.mem_byte_enable = '1;
      bus.illegal_instr   = 1'b0;

      if (rst) begin
         case (state_reg)
            s_fetch1: bus.load_mar = 1'b1;
            s_fetch2: begin
               bus.mem_read = 1'b1;
               bus.load_mdr = bus.mem_resp;
            end
            s_fetch3: bus.load_ir = 1'b1;
            s_decode: begin
`ifndef MP1_ILLEGAL_TRAP_EN
               // Unknown opcodes retire as a NOP straight from decode
               if (!opcode_known(bus.opcode)) bus.load_pc = 1'b1;
`endif
            end
            s_imm, s_reg: begin
               bus.load_regfile = 1'b1;
               bus.load_pc      = 1'b1;
               if (state_reg == s_reg) bus.alumux2_sel = alumux2_rs2_out;
               else                    bus.cmpmux_sel  = cmpmux_i_imm;
               case (arith_funct3_t'(bus.funct3))
                  f3_slt: begin
                     bus.cmpop          = blt;
                     bus.regfilemux_sel = regfilemux_br_en;
                  end
                  f3_sltu: begin
                     bus.cmpop          = bltu;
                     bus.regfilemux_sel = regfilemux_br_en;
                  end
                  default: begin
                     // Immediate adds ignore funct7; only srai uses the alt bit
                     bus.aluop = arith_aluop(bus.funct3,
                        bus.funct7[5] && (state_reg == s_reg || bus.funct3 == 3'(f3_sr)));
                  end
               endcase
            end
            s_lui: begin
               bus.regfilemux_sel = regfilemux_u_imm;
               bus.load_regfile   = 1'b1;
               bus.load_pc        = 1'b1;
            end
            s_auipc: begin
               bus.alumux1_sel  = alumux1_pc_out;
               bus.alumux2_sel  = alumux2_u_imm;
               bus.load_regfile = 1'b1;
               bus.load_pc      = 1'b1;
            end
            s_br: begin
               bus.alumux1_sel = alumux1_pc_out;
               bus.alumux2_sel = alumux2_b_imm;
               bus.cmpop       = branch_funct3_t'(bus.funct3);
               bus.pcmux_sel   = bus.br_en ? pcmux_alu_out : pcmux_pc_plus4;
               bus.load_pc     = 1'b1;
            end
            s_jal: begin
               bus.regfilemux_sel = regfilemux_pc_plus4;
               bus.load_regfile   = 1'b1;
               bus.alumux1_sel    = alumux1_pc_out;
               bus.alumux2_sel    = alumux2_j_imm;
               bus.pcmux_sel      = pcmux_alu_out;
               bus.load_pc        = 1'b1;
            end
            s_jalr: begin
               bus.regfilemux_sel = regfilemux_pc_plus4;
               bus.load_regfile   = 1'b1;
               bus.pcmux_sel      = pcmux_alu_mod2;
               bus.load_pc        = 1'b1;
            end
            s_calc_addr: begin
               bus.marmux_sel = marmux_alu_out;
               bus.load_mar   = 1'b1;
               if (bus.opcode == op_store) begin
                  bus.alumux2_sel   = alumux2_s_imm;
                  bus.load_data_out = 1'b1;
               end
            end
            s_ld1: begin
               bus.mem_read = 1'b1;
               bus.load_mdr = bus.mem_resp;
            end
            s_ld2: begin
               bus.load_regfile = 1'b1;
               bus.load_pc      = 1'b1;
               case (load_funct3_t'(bus.funct3))
                  lb:      bus.regfilemux_sel = regfilemux_lb;
                  lh:      bus.regfilemux_sel = regfilemux_lh;
                  lbu:     bus.regfilemux_sel = regfilemux_lbu;
                  lhu:     bus.regfilemux_sel = regfilemux_lhu;
                  default: bus.regfilemux_sel = regfilemux_lw;
               endcase
            end
            s_st1: begin
               bus.mem_write       = 1'b1;
               bus.mem_byte_enable = store_mask;
            end
            s_st2: bus.load_pc = 1'b1;
            s_trap: begin
`ifdef MP1_ILLEGAL_TRAP_EN
               bus.illegal_instr = 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mp1_control.sv
// Randomized instruction-level bench for mp1_control: the bench plays IR, comparator and memory,
// and checks per-instruction totals against a transaction model built from the instruction rules.
module tb_mp1_control;
   import mp1_control_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mp1_control_if bus();

   mp1_control dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Instruction classes used by the model
   localparam int C_IMM = 0, C_REG = 1, C_LUI = 2, C_AUIPC = 3, C_BR = 4, C_JAL = 5,
                  C_JALR = 6, C_LOAD = 7, C_STORE = 8, C_BAD = 9;
`ifdef MP1_ILLEGAL_TRAP_EN
   localparam int MAX_CLS = C_STORE;
`else
   localparam int MAX_CLS = C_BAD;
`endif

   int br_f3_tab[6] = '{0, 1, 4, 5, 6, 7};
   int ld_f3_tab[5] = '{0, 1, 2, 4, 5};

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic rv32i_opcode cls_opcode(input int cls);
      case (cls)
         C_IMM:   return op_imm;
         C_REG:   return op_reg;
         C_LUI:   return op_lui;
         C_AUIPC: return op_auipc;
         C_BR:    return op_br;
         C_JAL:   return op_jal;
         C_JALR:  return op_jalr;
         C_LOAD:  return op_load;
         C_STORE: return op_store;
         default: return rv32i_opcode'(7'b0000000);
      endcase
   endfunction

   function automatic alu_ops model_aluop(input int f3, input bit alt);
      case (f3)
         0:       return alt ? alu_sub : alu_add;
         1:       return alu_sll;
         4:       return alu_xor;
         5:       return alt ? alu_sra : alu_srl;
         6:       return alu_or;
         default: return alu_and;
      endcase
   endfunction

   function automatic int model_mask(input int f3, input int lsb);
      int nbytes;
      nbytes = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
      return (((1 << nbytes) - 1) << lsb) & 15;
   endfunction

   function automatic regfilemux_sel_t model_rfmux(input int cls, input int f3);
      case (cls)
         C_IMM, C_REG: return (f3 == 2 || f3 == 3) ? regfilemux_br_en : regfilemux_alu_out;
         C_LUI:        return regfilemux_u_imm;
         C_JAL, C_JALR: return regfilemux_pc_plus4;
         C_LOAD: begin
            case (f3)
               0:       return regfilemux_lb;
               1:       return regfilemux_lh;
               4:       return regfilemux_lbu;
               5:       return regfilemux_lhu;
               default: return regfilemux_lw;
            endcase
         end
         default:      return regfilemux_alu_out;
      endcase
   endfunction

   // Runs one instruction starting in fetch1 and stops as the next fetch1 appears.
   task automatic run_instr(input int cls, input int f3, input int f7, input bit bren,
                            input int fwait, input int dwait, input int lsb, input bit noise);
      int cyc = 0, wt = 0, req_idx = 0, planned;
      int n_ir = 0, n_mar = 0, n_mdr = 0, n_rf = 0, n_pc = 0, n_rd = 0, n_wr = 0, n_dout = 0, n_ill = 0;
      int rf_mux = -1, alu_rf = -1, cmp_rf = -1, pc_mux = -1, a2_pc = -1, cmp_pc = -1, mask_last = -1;
      int exp_cyc, exp_rf, exp_pcmux;
      bit req, done = 0;
      bus.opcode       = cls_opcode(cls);
      bus.funct3       = 3'(f3);
      bus.funct7       = 7'(f7);
      bus.br_en        = bren;
      bus.mem_addr_lsb = 2'(lsb);
      while (!done && cyc < 100) begin
         req     = bus.mem_read || bus.mem_write;
         planned = (req_idx == 0) ? fwait : dwait;
         bus.mem_resp = req ? (wt == planned) : (noise && $urandom_range(0, 1) == 1);
         #1;
         if (cyc > 0 && bus.load_mar && bus.marmux_sel == marmux_pc_out) begin
            done = 1;
         end else begin
            n_ir   += int'(bus.load_ir);
            n_mar  += int'(bus.load_mar);
            n_mdr  += int'(bus.load_mdr);
            n_rd   += int'(bus.mem_read);
            n_wr   += int'(bus.mem_write);
            n_dout += int'(bus.load_data_out);
            n_ill  += int'(bus.illegal_instr);
            if (bus.mem_write) mask_last = int'(bus.mem_byte_enable);
            if (bus.load_regfile) begin
               n_rf++;
               rf_mux = int'(bus.regfilemux_sel);
               alu_rf = int'(bus.aluop);
               cmp_rf = int'(bus.cmpop);
            end
            if (bus.load_pc) begin
               n_pc++;
               pc_mux = int'(bus.pcmux_sel);
               a2_pc  = int'(bus.alumux2_sel);
               cmp_pc = int'(bus.cmpop);
            end
            if (req) begin
               if (bus.mem_resp) begin
                  wt = 0;
                  req_idx++;
               end else begin
                  wt++;
               end
            end
            cyc++;
            @(negedge clk);
         end
      end
      bus.mem_resp = 1'b0;
      if (!done) check("timeout", 0, 1);

      // Fetch/decode take 4 cycles plus fetch waits; execute length depends on class
      exp_cyc = 4 + fwait;
      if (cls == C_LOAD || cls == C_STORE) exp_cyc += 3 + dwait;
      else if (cls != C_BAD)               exp_cyc += 1;
      exp_pcmux = (cls == C_JAL) ? int'(pcmux_alu_out) :
                  (cls == C_JALR) ? int'(pcmux_alu_mod2) :
                  (cls == C_BR && bren) ? int'(pcmux_alu_out) : int'(pcmux_pc_plus4);
      exp_rf = (cls == C_BR || cls == C_STORE || cls == C_BAD) ? 0 : 1;

      $display("instr cls=%0d f3=%0d f7=%0d br_en=%0d fwait=%0d dwait=%0d lsb=%0d cycles=%0d",
               cls, f3, f7, bren, fwait, dwait, lsb, cyc);
      check("cycles", cyc, exp_cyc);
      check("load_ir_cnt", n_ir, 1);
      check("load_pc_cnt", n_pc, 1);
      check("load_regfile_cnt", n_rf, exp_rf);
      check("load_mar_cnt", n_mar, (cls == C_LOAD || cls == C_STORE) ? 2 : 1);
      check("load_mdr_cnt", n_mdr, (cls == C_LOAD) ? 2 : 1);
      check("mem_read_cyc", n_rd, 1 + fwait + ((cls == C_LOAD) ? 1 + dwait : 0));
      check("mem_write_cyc", n_wr, (cls == C_STORE) ? 1 + dwait : 0);
      check("load_data_out_cnt", n_dout, (cls == C_STORE) ? 1 : 0);
      check("illegal_instr", n_ill, 0);
      check("pcmux", pc_mux, exp_pcmux);
      if (exp_rf == 1) check("regfilemux", rf_mux, int'(model_rfmux(cls, f3)));
      if ((cls == C_IMM || cls == C_REG) && f3 != 2 && f3 != 3)
         check("aluop", alu_rf, int'(model_aluop(f3, (cls == C_REG || f3 == 5) && f7 == 32)));
      if ((cls == C_IMM || cls == C_REG) && (f3 == 2 || f3 == 3))
         check("slt_cmpop", cmp_rf, (f3 == 2) ? int'(blt) : int'(bltu));
      if (cls == C_BR) check("br_cmpop", cmp_pc, f3);
      if (cls == C_IMM || cls == C_JALR) check("alumux2", a2_pc, int'(alumux2_i_imm));
      if (cls == C_REG)   check("alumux2", a2_pc, int'(alumux2_rs2_out));
      if (cls == C_AUIPC) check("alumux2", a2_pc, int'(alumux2_u_imm));
      if (cls == C_BR)    check("alumux2", a2_pc, int'(alumux2_b_imm));
      if (cls == C_JAL)   check("alumux2", a2_pc, int'(alumux2_j_imm));
      if (cls == C_STORE) check("byte_enable", mask_last, model_mask(f3, lsb));
   endtask

   initial begin
      int cls, f3, f7;
      rst              = 1'b0;
      bus.opcode       = op_imm;
      bus.funct3       = 3'd0;
      bus.funct7       = 7'd0;
      bus.br_en        = 1'b0;
      bus.mem_resp     = 1'b0;
      bus.mem_addr_lsb = 2'd0;

      // Reset defaults
      @(negedge clk);
      bus.mem_resp = 1'b1;
      #1;
      check("rst_mem_read", int'(bus.mem_read), 0);
      check("rst_load_mar", int'(bus.load_mar), 0);
      check("rst_load_mdr", int'(bus.load_mdr), 0);
      check("rst_byte_enable", int'(bus.mem_byte_enable), 15);
      check("rst_aluop", int'(bus.aluop), int'(alu_add));
      bus.mem_resp = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("release_fetch1", int'(bus.load_mar), 1);

      // Directed: addi, beq taken/not taken, lw with waits, sb/sh masks, unknown opcode
      run_instr(C_IMM, 0, 0, 1'b0, 0, 0, 0, 1'b0);
      run_instr(C_BR, 0, 0, 1'b1, 0, 0, 0, 1'b0);
      run_instr(C_BR, 0, 0, 1'b0, 0, 0, 0, 1'b0);
      run_instr(C_LOAD, 2, 0, 1'b0, 0, 3, 0, 1'b0);
      run_instr(C_STORE, 0, 0, 1'b0, 0, 0, 3, 1'b0);
      run_instr(C_STORE, 1, 0, 1'b0, 1, 2, 2, 1'b0);
      run_instr(C_STORE, 1, 0, 1'b0, 0, 0, 3, 1'b0);
      run_instr(C_STORE, 2, 0, 1'b0, 0, 0, 1, 1'b0);
      run_instr(C_REG, 0, 32, 1'b0, 0, 0, 0, 1'b0);
      run_instr(C_IMM, 5, 32, 1'b0, 0, 0, 0, 1'b0);
`ifndef MP1_ILLEGAL_TRAP_EN
      run_instr(C_BAD, 0, 0, 1'b0, 0, 0, 0, 1'b0);
`endif

      // Random stream with stray mem_resp outside memory states
      for (int i = 0; i < 40; i++) begin
         cls = $urandom_range(0, MAX_CLS);
         f3  = $urandom_range(0, 7);
         f7  = 0;
         if (cls == C_BR)    f3 = br_f3_tab[$urandom_range(0, 5)];
         if (cls == C_LOAD)  f3 = ld_f3_tab[$urandom_range(0, 4)];
         if (cls == C_STORE) f3 = $urandom_range(0, 2);
         if ((cls == C_IMM && f3 == 5) || (cls == C_REG && (f3 == 0 || f3 == 5)))
            f7 = $urandom_range(0, 1) * 32;
         run_instr(cls, f3, f7, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      end

      // Reset during a fetch wait
      bus.opcode   = op_imm;
      bus.mem_resp = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("wait_mem_read", int'(bus.mem_read), 1);
      rst = 1'b0;
      #1;
      check("async_mem_read", int'(bus.mem_read), 0);
      check("async_load_mdr", int'(bus.load_mdr), 0);
      check("async_load_mar", int'(bus.load_mar), 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("restart_load_mar", int'(bus.load_mar), 1);
      check("restart_marmux", int'(bus.marmux_sel), int'(marmux_pc_out));
      run_instr(C_IMM, 4, 0, 1'b0, 1, 0, 0, 1'b0);

`ifdef MP1_ILLEGAL_TRAP_EN
      begin
         int n_ill = 0, n_act = 0;
         bus.opcode = rv32i_opcode'(7'b0000000);
         for (int i = 0; i < 30; i++) begin
            bus.mem_resp = bus.mem_read;
            #1;
            n_ill += int'(bus.illegal_instr);
            if (i >= 4)
               n_act += int'(bus.mem_read || bus.mem_write || bus.load_pc || bus.load_ir ||
                             bus.load_mar || bus.load_mdr || bus.load_regfile || bus.load_data_out);
            @(negedge clk);
         end
         bus.mem_resp = 1'b0;
         $display("trap illegal_cycles=%0d activity=%0d", n_ill, n_act);
         check("trap_illegal_cycles", n_ill, 26);
         check("trap_activity", n_act, 0);
         rst = 1'b0;
         #1;
         check("trap_rst_clear", int'(bus.illegal_instr), 0);
         @(negedge clk);
         rst = 1'b1;
         #1;
         check("trap_restart", int'(bus.load_mar), 1);
         run_instr(C_LUI, 0, 0, 1'b0, 0, 0, 0, 1'b0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
